// File: rtl/regf_pkg.sv
// Shared definitions for the GPIO-driven register bank: command opcodes,
// status word layout, version tag and snapshot FSM state encoding.
package regf_pkg;

  localparam logic [7:0] OP_RST_SOFT  = 8'h01;
  localparam logic [7:0] OP_EN_RX     = 8'h02;
  localparam logic [7:0] OP_LOG_CTRL  = 8'h03;
  localparam logic [7:0] OP_RAM_READ  = 8'h04;
  localparam logic [7:0] OP_SNAPSHOT  = 8'h05;
  localparam logic [7:0] OP_CNT_READ  = 8'h06;
  localparam logic [7:0] OP_STATUS    = 8'h07;

  localparam logic [7:0] REGF_VERSION = 8'h02;

  // Command word layout
  localparam int CMD_OP_LSB     = 24;
  localparam int CMD_STROBE_BIT = 23;
  localparam int PAY_MODE_BIT   = 16;

  // Status word layout
  localparam int ST_VER_LSB  = 24;
  localparam int ST_OP_LSB   = 16;
  localparam int ST_BIT_DONE = 2;
  localparam int ST_BIT_ERR  = 1;
  localparam int ST_BIT_WAIT = 0;

  typedef enum logic [1:0] {
    SNAP_IDLE = 2'd0,
    SNAP_WAIT = 2'd1,
    SNAP_DONE = 2'd2
  } snap_state_t;

  // Opcodes 01..07 are the only ones the bank acts on.
  function automatic logic is_known_op(input logic [7:0] op);
    return (op >= OP_RST_SOFT) && (op <= OP_STATUS);
  endfunction

endpackage

// File: rtl/regf_snapshot.sv
// Counter snapshot engine: waits for a coherent counter cycle after a
// request, captures every channel's err/bit counters at once, and serves
// one GPIO-wide word of the captured values selected by {ch, type, word}.
module regf_snapshot
  import regf_pkg::*;
#(
  parameter int NBT_GPIOS = 32,
  parameter int NBT_COUNT = 64,
  parameter int N_CH      = 2
) (
  input  logic                      clk,
  input  logic                      i_reset,
  input  logic                      snap_req,
  input  logic                      cnt_valid,
  input  logic [N_CH*NBT_COUNT-1:0] accum_err,
  input  logic [N_CH*NBT_COUNT-1:0] accum_bit,
  input  logic [15:0]               sel,
  output logic [NBT_GPIOS-1:0]      rd_word,
  output logic                      busy,
  output logic                      snap_done
);

  localparam int NW = NBT_COUNT / NBT_GPIOS;
  localparam int WB = (NW > 1) ? $clog2(NW) : 0;

  snap_state_t state, state_nxt;
  logic        capture;

  logic [N_CH*NBT_COUNT-1:0] snap_err;
  logic [N_CH*NBT_COUNT-1:0] snap_bit;

  logic [15:0]          ch_field;
  logic [15:0]          word_field;
  logic                 type_bit;
  logic [NBT_COUNT-1:0] src;

  // State register; reset abandons any pending wait.
  always_ff @(posedge clk) begin
    if (i_reset) state <= SNAP_IDLE;
    else         state <= state_nxt;
  end

  // Next state and capture strobe; a request while waiting is ignored.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      SNAP_IDLE, SNAP_DONE: begin
        if (snap_req) state_nxt = SNAP_WAIT;
      end
      SNAP_WAIT: begin
        if (cnt_valid) begin
          capture   = 1'b1;
          state_nxt = SNAP_DONE;
        end
      end
      default: state_nxt = SNAP_IDLE;
    endcase
  end

  // Capture all channels in the single coherent cycle.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      snap_err <= '0;
      snap_bit <= '0;
    end else if (capture) begin
      snap_err <= accum_err;
      snap_bit <= accum_bit;
    end
  end

  assign busy      = (state == SNAP_WAIT);
  assign snap_done = (state == SNAP_DONE);

  // Select layout, LSB first: word index, counter type, channel.
  assign ch_field   = sel >> (WB + 1);
  assign type_bit   = sel[WB];
  assign word_field = sel & 16'((1 << WB) - 1);

  // Word mux; an absent channel or word reads as zero.
  always_comb begin
    src     = '0;
    rd_word = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (ch_field == 16'(c))
        src = type_bit ? snap_bit[c*NBT_COUNT +: NBT_COUNT]
                       : snap_err[c*NBT_COUNT +: NBT_COUNT];
    end
    for (int w = 0; w < NW; w++) begin
      if (word_field == 16'(w))
        rd_word = src[w*NBT_GPIOS +: NBT_GPIOS];
    end
  end

endmodule

// File: rtl/gpio_reg_bank.sv
// GPIO-commanded register bank: decodes strobed command words into control
// registers, triggers counter snapshots, and returns a registered readback
// word from RAM, captured counters or the status word.
module gpio_reg_bank
  import regf_pkg::*;
#(
  parameter int NBT_GPIOS = 32,
  parameter int RAM_DEPTH = 32768,
  parameter int NBT_COUNT = 64,
  parameter int N_CH      = 2,
  localparam int AW       = $clog2(RAM_DEPTH)
) (
  input  logic                      clk,
  input  logic                      i_reset,
  input  logic [NBT_GPIOS-1:0]      i_gpio_to_regf,
  output logic [NBT_GPIOS-1:0]      o_regf_to_gpio,
  input  logic [N_CH*NBT_COUNT-1:0] i_accum_err,
  input  logic [N_CH*NBT_COUNT-1:0] i_accum_bit,
  input  logic                      i_cnt_valid,
  input  logic [NBT_GPIOS-1:0]      i_data_ram_for_read,
  output logic                      o_rst_soft,
  output logic                      o_en_rx_soft,
  output logic                      o_en_write,
  output logic                      o_en_read_from_ram,
  output logic [2:0]                o_data_sel_for_log,
  output logic [AW-1:0]             o_read_adrs
);

  // Command fields sit at fixed bit positions of a 32-bit word; narrower
  // or wider GPIO buses are zero-extended/kept to reach them.
  localparam int CW = (NBT_GPIOS > 32) ? NBT_GPIOS : 32;

  logic [CW-1:0] cmd_w;
  logic [7:0]    opcode;
  logic          strobe;
  logic          strobe_q;
  logic          cmd_edge;
  logic          unused_cmd_bits;

  logic          ram_mode;
  logic          cnt_mode;
  logic          status_mode;
  logic [15:0]   cnt_sel;
  logic          cmd_err;
  logic [7:0]    last_op;

  logic                 snap_req;
  logic                 snap_busy;
  logic                 snap_done;
  logic [NBT_GPIOS-1:0] cnt_word;
  logic [CW-1:0]        status_w;
  logic [NBT_GPIOS-1:0] rb;

  assign cmd_w    = CW'(i_gpio_to_regf);
  assign opcode   = cmd_w[CMD_OP_LSB +: 8];
  assign strobe   = cmd_w[CMD_STROBE_BIT];
  assign cmd_edge = strobe & ~strobe_q;
  assign snap_req = cmd_edge && (opcode == OP_SNAPSHOT) && cmd_w[0];

  // Payload bits no opcode consumes.
  assign unused_cmd_bits = ^cmd_w;

  // Command execution on the strobe rising edge only.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      strobe_q           <= 1'b0;
      o_rst_soft         <= 1'b1;
      o_en_rx_soft       <= 1'b1;
      o_en_write         <= 1'b0;
      o_data_sel_for_log <= 3'd0;
      o_read_adrs        <= '0;
      ram_mode           <= 1'b0;
      cnt_mode           <= 1'b0;
      status_mode        <= 1'b0;
      cnt_sel            <= 16'd0;
      cmd_err            <= 1'b0;
      last_op            <= 8'd0;
    end else begin
      strobe_q <= strobe;
      if (cmd_edge) begin
        case (opcode)
          OP_RST_SOFT: o_rst_soft   <= cmd_w[0];
          OP_EN_RX:    o_en_rx_soft <= cmd_w[0];
          OP_LOG_CTRL: begin
            o_data_sel_for_log <= cmd_w[2:0];
            o_en_write         <= cmd_w[3];
          end
          OP_RAM_READ: begin
            o_read_adrs <= cmd_w[AW-1:0];
            ram_mode    <= cmd_w[PAY_MODE_BIT];
          end
          OP_SNAPSHOT: ;
          OP_CNT_READ: begin
            cnt_mode <= cmd_w[PAY_MODE_BIT];
            cnt_sel  <= cmd_w[15:0];
          end
          OP_STATUS: begin
            status_mode <= cmd_w[PAY_MODE_BIT];
            if (cmd_w[0]) cmd_err <= 1'b0;
          end
          default: cmd_err <= 1'b1;
        endcase
        if (is_known_op(opcode)) last_op <= opcode;
      end
    end
  end

  assign o_en_read_from_ram = ram_mode;

  regf_snapshot #(
    .NBT_GPIOS (NBT_GPIOS),
    .NBT_COUNT (NBT_COUNT),
    .N_CH      (N_CH)
  ) u_snapshot (
    .clk       (clk),
    .i_reset   (i_reset),
    .snap_req  (snap_req),
    .cnt_valid (i_cnt_valid),
    .accum_err (i_accum_err),
    .accum_bit (i_accum_bit),
    .sel       (cnt_sel),
    .rd_word   (cnt_word),
    .busy      (snap_busy),
    .snap_done (snap_done)
  );

  // Status word assembly.
  always_comb begin
    status_w                   = '0;
    status_w[ST_VER_LSB +: 8]  = REGF_VERSION;
    status_w[ST_OP_LSB +: 8]   = last_op;
    status_w[ST_BIT_DONE]      = snap_done;
    status_w[ST_BIT_ERR]       = cmd_err;
    status_w[ST_BIT_WAIT]      = snap_busy;
  end

  // Registered readback: RAM over counters over status, else zero.
  always_ff @(posedge clk) begin
    if (i_reset)          rb <= '0;
    else if (ram_mode)    rb <= i_data_ram_for_read;
    else if (cnt_mode)    rb <= cnt_word;
    else if (status_mode) rb <= status_w[NBT_GPIOS-1:0];
    else                  rb <= '0;
  end

  assign o_regf_to_gpio = rb;

endmodule

// File: tb/tb_gpio_reg_bank.sv
// Directed bench for gpio_reg_bank: control-register vector table plus
// hand-written sequences for strobe hold, snapshot, RAM readback and reset.
module tb_gpio_reg_bank;

  logic         clk;
  logic         rst;
  logic [31:0]  cmd;
  logic [31:0]  rdbk;
  logic [127:0] acc_err;
  logic [127:0] acc_bit;
  logic         cnt_valid;
  logic [31:0]  ram_data;
  logic         rst_soft, en_rx, en_wr, en_rd;
  logic [2:0]   dsel;
  logic [14:0]  adrs;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    logic [7:0]  op;
    logic [22:0] pay;
    logic        rst_soft;
    logic        en_rx;
    logic [2:0]  sel;
    logic        wr;
    logic [14:0] adrs;
    logic [31:0] stat;
  } vec_t;

  vec_t tbl [12];

  gpio_reg_bank dut (
    .clk                 (clk),
    .i_reset             (rst),
    .i_gpio_to_regf      (cmd),
    .o_regf_to_gpio      (rdbk),
    .i_accum_err         (acc_err),
    .i_accum_bit         (acc_bit),
    .i_cnt_valid         (cnt_valid),
    .i_data_ram_for_read (ram_data),
    .o_rst_soft          (rst_soft),
    .o_en_rx_soft        (en_rx),
    .o_en_write          (en_wr),
    .o_en_read_from_ram  (en_rd),
    .o_data_sel_for_log  (dsel),
    .o_read_adrs         (adrs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else pass_cnt++;
  endtask

  // One strobe pulse; returns 1ns after the edge at which readback reflects it.
  task automatic send(input logic [7:0] op, input logic [22:0] pay);
    cmd = {op, 1'b1, pay};
    @(posedge clk); #1;
    cmd = {op, 1'b0, pay};
    @(posedge clk); #1;
  endtask

  initial begin
    tbl[0]  = '{8'h01, 23'h000000, 1'b0, 1'b0, 3'd0, 1'b0, 15'h0000, 32'h0201_0000};
    tbl[1]  = '{8'h03, 23'h00000D, 1'b0, 1'b0, 3'd5, 1'b1, 15'h0000, 32'h0203_0000};
    tbl[2]  = '{8'h01, 23'h000001, 1'b1, 1'b0, 3'd5, 1'b1, 15'h0000, 32'h0201_0000};
    tbl[3]  = '{8'h02, 23'h000001, 1'b1, 1'b1, 3'd5, 1'b1, 15'h0000, 32'h0202_0000};
    tbl[4]  = '{8'h04, 23'h000ABC, 1'b1, 1'b1, 3'd5, 1'b1, 15'h0ABC, 32'h0204_0000};
    tbl[5]  = '{8'h03, 23'h000006, 1'b1, 1'b1, 3'd6, 1'b0, 15'h0ABC, 32'h0203_0000};
    tbl[6]  = '{8'h04, 23'h00FFFF, 1'b1, 1'b1, 3'd6, 1'b0, 15'h7FFF, 32'h0204_0000};
    tbl[7]  = '{8'h3F, 23'h7FFFFF, 1'b1, 1'b1, 3'd6, 1'b0, 15'h7FFF, 32'h0204_0002};
    tbl[8]  = '{8'h00, 23'h000000, 1'b1, 1'b1, 3'd6, 1'b0, 15'h7FFF, 32'h0204_0002};
    tbl[9]  = '{8'h07, 23'h010001, 1'b1, 1'b1, 3'd6, 1'b0, 15'h7FFF, 32'h0207_0000};
    tbl[10] = '{8'h02, 23'h7FFFFE, 1'b1, 1'b0, 3'd6, 1'b0, 15'h7FFF, 32'h0202_0000};
    tbl[11] = '{8'h01, 23'h7FFFFE, 1'b0, 1'b0, 3'd6, 1'b0, 15'h7FFF, 32'h0201_0000};

    rst = 1'b1; cmd = '0; cnt_valid = 1'b0;
    acc_err = '0; acc_bit = '0; ram_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_rst_soft", 64'(rst_soft), 64'd1);
    chk("rst_en_rx",    64'(en_rx),    64'd1);
    chk("rst_en_write", 64'(en_wr),    64'd0);
    chk("rst_en_read",  64'(en_rd),    64'd0);
    chk("rst_data_sel", 64'(dsel),     64'd0);
    chk("rst_adrs",     64'(adrs),     64'd0);
    chk("rst_readback", 64'(rdbk),     64'd0);

    // Enable status readback
    send(8'h07, 23'h010000);
    chk("status_on", 64'(rdbk), 64'h0207_0000);

    // Strobe held high ten cycles executes once
    cmd = {8'h02, 1'b1, 23'h000000};
    @(posedge clk); #1;
    chk("hold_first_edge", 64'(en_rx), 64'd0);
    repeat (9) @(posedge clk);
    #1 chk("hold_10cyc", 64'(en_rx), 64'd0);
    cmd = {8'h02, 1'b1, 23'h000001};
    repeat (2) @(posedge clk);
    #1 chk("hold_no_reexec", 64'(en_rx), 64'd0);
    cmd = {8'h02, 1'b0, 23'h000001};
    @(posedge clk); #1;
    chk("hold_last_op", 64'(rdbk), 64'h0202_0000);

    // Control-register vector table
    for (int i = 0; i < 12; i++) begin
      send(tbl[i].op, tbl[i].pay);
      chk($sformatf("row%0d_rst_soft", i), 64'(rst_soft), 64'(tbl[i].rst_soft));
      chk($sformatf("row%0d_en_rx", i),    64'(en_rx),    64'(tbl[i].en_rx));
      chk($sformatf("row%0d_sel", i),      64'(dsel),     64'(tbl[i].sel));
      chk($sformatf("row%0d_en_write", i), 64'(en_wr),    64'(tbl[i].wr));
      chk($sformatf("row%0d_adrs", i),     64'(adrs),     64'(tbl[i].adrs));
      chk($sformatf("row%0d_status", i),   64'(rdbk),     64'(tbl[i].stat));
    end

    // Snapshot: request, coherent cycle five cycles later, then read back
    acc_err = {64'h1111_2222_3333_4444, 64'h0000_0001_0000_0002};
    acc_bit = {64'h5555_6666_7777_8888, 64'hAAAA_BBBB_CCCC_DDDD};
    send(8'h05, 23'h000001);
    chk("snap_wait_status", 64'(rdbk), 64'h0205_0001);
    repeat (5) @(posedge clk);
    #1 chk("snap_still_wait", 64'(rdbk), 64'h0205_0001);
    cnt_valid = 1'b1;
    @(posedge clk); #1;
    cnt_valid = 1'b0;
    acc_err = '1;
    acc_bit = '1;
    @(posedge clk); #1;
    chk("snap_done_status", 64'(rdbk), 64'h0205_0004);
    send(8'h06, 23'h010000);
    chk("cnt_sel0_err_lsw", 64'(rdbk), 64'h0000_0002);
    send(8'h06, 23'h010001);
    chk("cnt_sel1_err_msw", 64'(rdbk), 64'h0000_0001);
    send(8'h06, 23'h010002);
    chk("cnt_sel2_bit_lsw", 64'(rdbk), 64'hCCCC_DDDD);
    send(8'h06, 23'h010005);
    chk("cnt_sel5_ch1_err_msw", 64'(rdbk), 64'h1111_2222);
    send(8'h06, 23'h010007);
    chk("cnt_sel7_ch1_bit_msw", 64'(rdbk), 64'h5555_6666);
    send(8'h06, 23'h010008);
    chk("cnt_ch2_zero", 64'(rdbk), 64'h0);
    send(8'h06, 23'h01000C);
    chk("cnt_ch3_zero", 64'(rdbk), 64'h0);

    // Strobe edge coincident with the coherent cycle while waiting
    send(8'h05, 23'h000001);
    acc_err = {64'h0, 64'h0000_0003_0000_0009};
    cnt_valid = 1'b1;
    cmd = {8'h06, 1'b1, 23'h010000};
    @(posedge clk); #1;
    cnt_valid = 1'b0;
    cmd = {8'h06, 1'b0, 23'h010000};
    @(posedge clk); #1;
    chk("coincident_capture", 64'(rdbk), 64'h0000_0009);

    // RAM readback overrides counter mode, one cycle behind the mode change
    ram_data = 32'hCAFE_0001;
    cmd = {8'h04, 1'b1, 23'h011234};
    @(posedge clk); #1;
    chk("ram_adrs", 64'(adrs), 64'h1234);
    chk("ram_en_read", 64'(en_rd), 64'd1);
    chk("ram_latency_old", 64'(rdbk), 64'h0000_0009);
    cmd = {8'h04, 1'b0, 23'h011234};
    @(posedge clk); #1;
    chk("ram_readback", 64'(rdbk), 64'hCAFE_0001);
    ram_data = 32'h1234_5678;
    @(posedge clk); #1;
    chk("ram_follow", 64'(rdbk), 64'h1234_5678);
    send(8'h04, 23'h001234);
    chk("ram_off_en_read", 64'(en_rd), 64'd0);
    chk("ram_off_counter", 64'(rdbk), 64'h0000_0009);

    // Reset in the middle of a wait, with a coherent cycle on the same edge
    send(8'h05, 23'h000001);
    acc_err = {64'h0, 64'h0000_0000_0000_0005};
    cnt_valid = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    cnt_valid = 1'b0;
    chk("midrst_rst_soft", 64'(rst_soft), 64'd1);
    chk("midrst_en_rx",    64'(en_rx),    64'd1);
    chk("midrst_adrs",     64'(adrs),     64'd0);
    chk("midrst_readback", 64'(rdbk),     64'd0);
    send(8'h07, 23'h010000);
    chk("midrst_status_idle", 64'(rdbk), 64'h0207_0000);
    send(8'h06, 23'h010000);
    chk("midrst_snap_lsw_zero", 64'(rdbk), 64'h0);
    send(8'h06, 23'h010001);
    chk("midrst_snap_msw_zero", 64'(rdbk), 64'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
